// File: rtl/ct_spsram_param_init_pkg.sv
// Shared definitions for the parameterised single-port SRAM with init sequencer:
// FSM state encoding and the write-enable slicing legality helpers.
package ct_spsram_param_init_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // A write-enable bit must cover a whole, equal-sized group of data bits.
  function automatic bit widths_legal(input int data_width, input int we_width);
    return (we_width > 0) && (data_width >= we_width) && ((data_width % we_width) == 0);
  endfunction

  // Number of data bits gated by one write-enable bit.
  function automatic int slice_width(input int data_width, input int we_width);
    return (we_width > 0) ? (data_width / we_width) : 1;
  endfunction

endpackage

// File: rtl/ct_spsram_param_array.sv
// Behavioural single-port array with per-slice active-low write mask and a
// registered read port. Q only changes on a read; writes never touch it.
module ct_spsram_param_array
  import ct_spsram_param_init_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 52,
  parameter int WE_WIDTH   = 52
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_ce,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [WE_WIDTH-1:0]   i_wen_n,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  localparam int S     = slice_width(DATA_WIDTH, WE_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;

  // Masked write: only slices whose enable is low are updated.
  // NOTE: the storage array has no reset; clearing it is the job of the init sequencer.
  always_ff @(posedge CLK) begin
    if (i_ce && i_we) begin
      for (int i = 0; i < WE_WIDTH; i++) begin
        if (!i_wen_n[i]) begin
          r_mem[i_addr][i*S +: S] <= i_d[i*S +: S];
        end
      end
    end
  end

  // Registered read data; holds its value on every non-read cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= '0;
    end else if (i_ce && !i_we) begin
      r_q <= r_mem[i_addr];
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ct_spsram_param_init.sv
// Single-port SRAM wrapper that clears the whole array to INIT_VAL after reset
// or on request, drops user accesses while doing so, and optionally adds an
// output register stage behind the array read port.
module ct_spsram_param_init
  import ct_spsram_param_init_pkg::*;
#(
  parameter int                       ADDR_WIDTH = 9,
  parameter int                       DATA_WIDTH = 52,
  parameter int                       WE_WIDTH   = 52,
  parameter int                       OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0]    INIT_VAL   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  INIT_REQ,
  output logic                  INIT_BUSY,
  output logic                  INIT_DONE,
  output logic                  ACC_DROP
);

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  if (!widths_legal(DATA_WIDTH, WE_WIDTH)) begin : g_bad_we_width
    $error("DATA_WIDTH must be a non-zero integer multiple of WE_WIDTH");
  end
  if ((OUT_REG != 0) && (OUT_REG != 1)) begin : g_bad_out_reg
    $error("OUT_REG must be 0 or 1");
  end

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_done;
  logic                  r_drop;
  logic                  w_busy;
  logic                  w_last;
  logic                  w_mem_ce;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [WE_WIDTH-1:0]   w_mem_wen_n;
  logic [DATA_WIDTH-1:0] w_mem_d;
  logic [DATA_WIDTH-1:0] w_arr_q;

  // State register.
  // NOTE: sequential state is always updated with non-blocking assignments.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_INIT;
    else     r_state <= w_next_state;
  end

  // Next-state logic: INIT runs to the last address; INIT_REQ only matters in IDLE.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT: if (r_cnt == CNT_LAST) w_next_state = ST_IDLE;
      ST_IDLE: if (INIT_REQ)          w_next_state = ST_INIT;
      default: w_next_state = ST_INIT;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_busy = (r_state == ST_INIT);
    w_last = w_busy && (r_cnt == CNT_LAST);
  end

  // Init address counter; wraps to 0 on the final init write, so IDLE always sees 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Completion and dropped-access pulses, each visible for the cycle after the event.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_done <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_done <= w_last;
      r_drop <= w_busy && !CEN;
    end
  end

  // Array port mux: the sequencer owns the port while busy; nothing moves in reset.
  always_comb begin
    w_mem_ce    = !RST && (w_busy || !CEN);
    w_mem_we    = w_busy || !GWEN;
    w_mem_addr  = w_busy ? r_cnt : A;
    w_mem_wen_n = w_busy ? '0 : WEN;
    w_mem_d     = w_busy ? INIT_VAL : D;
  end

  ct_spsram_param_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .WE_WIDTH   (WE_WIDTH)
  ) u_array (
    .CLK     (CLK),
    .RST     (RST),
    .i_ce    (w_mem_ce),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wen_n (w_mem_wen_n),
    .i_d     (w_mem_d),
    .o_q     (w_arr_q)
  );

  if (OUT_REG == 1) begin : g_out_reg
    logic [DATA_WIDTH-1:0] r_q_pipe;
    // Extra output stage; follows the array Q one cycle later, so it also holds.
    always_ff @(posedge CLK) begin
      if (RST) r_q_pipe <= '0;
      else     r_q_pipe <= w_arr_q;
    end
    assign Q = r_q_pipe;
  end else begin : g_no_out_reg
    assign Q = w_arr_q;
  end

  assign INIT_BUSY = w_busy;
  assign INIT_DONE = r_done;
  assign ACC_DROP  = r_drop;

endmodule
